// File: rtl/sram_rsp_pkg.sv
// ---------------------------------------------------------------------------
// sram_rsp_pkg
//   Shared definitions for the SRAM responder slice: FSM state encodings,
//   the wait-counter width and the latched request record.
//   Optional feature macro used by the slice: SRAM_RSP_BOUND_CHK_EN
//   (out-of-range address detection, see sram_rsp.sv).
// ---------------------------------------------------------------------------
package sram_rsp_pkg;

   // FSM encodings, kept as plain 2-bit constants so older tooling and
   // waveform decoders that expect raw values keep working.
   localparam logic [1:0] SRAM_RSP_IDLE = 2'd0;
   localparam logic [1:0] SRAM_RSP_WAIT = 2'd1;
   localparam logic [1:0] SRAM_RSP_RSP  = 2'd2;

   // Wide enough for WAIT_CYCLES in 0..15.
   localparam int SRAM_RSP_CNT_W = 4;

   // Request fields that must survive the wait period. The word index is
   // kept separately because its width depends on DEPTH.
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  sel;
      logic        we;
      logic        oor;
   } sram_rsp_req_t;

endpackage

// File: rtl/sram_rsp_mem.sv
// ---------------------------------------------------------------------------
// sram_rsp_mem
//   Single-port 32-bit word array with four byte-write enables and a
//   registered read port. Deliberately has no reset so it maps onto
//   block RAM.
//   Ports:
//     clk      in   clock
//     we_i     in   write strobe for this cycle
//     re_i     in   read strobe; rdata_o updates on the next edge
//     be_i     in   byte-lane write enables, be_i[k] -> bits [8k+7:8k]
//     addr_i   in   word index
//     wdata_i  in   write data
//     rdata_o  out  registered read data, holds until the next read
// ---------------------------------------------------------------------------
module sram_rsp_mem #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // Byte-lane writes. Each lane is written independently so synthesis
   // can use the RAM's native byte enables.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (we_i && be_i[k]) begin
            mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
         end
      end
   end

   // Read port only loads on a read strobe, so the data stays put while
   // the responder is stalled on rsp_ready_i.
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_rsp.sv
// ---------------------------------------------------------------------------
// sram_rsp
//   Single-port SRAM responder on the core's req/rsp bus. Accepts one
//   request per handshake, applies byte-lane writes or performs word
//   reads, and returns the result on the rsp channel. At most one
//   transaction is in flight.
//   Ports:
//     clk          in   clock
//     rst_n        in   asynchronous active-low reset
//     addr_i       in   byte address, word index = addr_i[AW+1:2]
//     data_i       in   write data
//     sel_i        in   byte-lane enables for writes (ignored on reads)
//     we_i         in   1 = write, 0 = read
//     req_valid_i  in   request valid
//     req_ready_o  out  request accepted when valid & ready
//     data_o       out  read data, zero for writes, valid with rsp_valid_o
//     rsp_valid_o  out  response valid
//     rsp_ready_i  in   response consumed when valid & ready
//     rsp_err_o    out  out-of-range access flag, qualified by rsp_valid_o
//   Parameters:
//     DEPTH        number of 32-bit words, power of two
//     WAIT_CYCLES  extra cycles between accept and response (0..15)
//   Configuration macro:
//     SRAM_RSP_BOUND_CHK_EN  when defined, addresses beyond DEPTH words are
//                            flagged with rsp_err_o, writes to them are
//                            dropped and reads return 0. When undefined the
//                            upper address bits are ignored (aliasing) and
//                            rsp_err_o is tied low.
// ---------------------------------------------------------------------------
module sram_rsp
   import sram_rsp_pkg::*;
#(
   parameter int DEPTH       = 4096,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  sel_i,
   input  logic        we_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   output logic [31:0] data_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_err_o
);

   localparam int AW = $clog2(DEPTH);

   logic [1:0]                state_q, state_d;
   logic [SRAM_RSP_CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]             idx_q, idx_d;
   sram_rsp_req_t             req_q, req_d;
   logic                      err_q, err_d;
   logic                      rd_ok_q, rd_ok_d;

   sram_rsp_req_t             in_req;
   logic [AW-1:0]             in_idx;
   logic                      accept;

   logic                      acc_en;
   logic [AW-1:0]             acc_idx;
   sram_rsp_req_t             acc_req;

   logic                      mem_we;
   logic                      mem_re;
   logic [31:0]               mem_rdata;

   // Request side: always ready when idle; while a response is pending a
   // new request may only be taken in the same cycle the response leaves.
   assign req_ready_o = (state_q == SRAM_RSP_IDLE) ||
                        ((state_q == SRAM_RSP_RSP) && rsp_ready_i);
   assign accept      = req_valid_i && req_ready_o;

   // Decode the incoming request into the form that is latched. The
   // out-of-range flag is computed once here so the wait path does not
   // need the upper address bits.
   always_comb begin
      in_req      = '0;
      in_req.data = data_i;
      in_req.sel  = sel_i;
      in_req.we   = we_i;
`ifdef SRAM_RSP_BOUND_CHK_EN
      in_req.oor  = (addr_i >> (AW + 2)) != 32'd0;
`else
      in_req.oor  = 1'b0;
`endif
      in_idx      = addr_i[AW+1:2];
   end

   // Next-state logic. The access to the array happens on the edge that
   // moves the FSM into RSP: straight from the accept when there are no
   // wait cycles (using the live request), otherwise from WAIT when the
   // counter has run out (using the latched request).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      req_d   = req_q;
      err_d   = err_q;
      rd_ok_d = rd_ok_q;
      acc_en  = 1'b0;
      acc_idx = idx_q;
      acc_req = req_q;

      case (state_q)
         SRAM_RSP_IDLE, SRAM_RSP_RSP: begin
            if ((state_q == SRAM_RSP_RSP) && rsp_ready_i) begin
               state_d = SRAM_RSP_IDLE;
            end
            if (accept) begin
               idx_d = in_idx;
               req_d = in_req;
               if (WAIT_CYCLES == 0) begin
                  acc_en  = 1'b1;
                  acc_idx = in_idx;
                  acc_req = in_req;
                  state_d = SRAM_RSP_RSP;
               end else begin
                  cnt_d   = SRAM_RSP_CNT_W'(WAIT_CYCLES - 1);
                  state_d = SRAM_RSP_WAIT;
               end
            end
         end
         SRAM_RSP_WAIT: begin
            if (cnt_q == '0) begin
               acc_en  = 1'b1;
               state_d = SRAM_RSP_RSP;
            end else begin
               cnt_d = cnt_q - SRAM_RSP_CNT_W'(1);
            end
         end
         default: begin
            state_d = SRAM_RSP_IDLE;
         end
      endcase

      // Response qualifiers are captured together with the access so they
      // stay stable for as long as the response is stalled.
      if (acc_en) begin
         err_d   = acc_req.oor;
         rd_ok_d = !acc_req.we && !acc_req.oor;
      end
   end

   // State registers. The array itself is not reset; an abort before the
   // access edge simply never strobes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SRAM_RSP_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         req_q   <= '0;
         err_q   <= 1'b0;
         rd_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         req_q   <= req_d;
         err_q   <= err_d;
         rd_ok_q <= rd_ok_d;
      end
   end

   // Out-of-range writes never reach the array; reads still strobe it but
   // their data is masked off below.
   assign mem_we = acc_en && acc_req.we && !acc_req.oor;
   assign mem_re = acc_en && !acc_req.we;

   sram_rsp_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .be_i    (acc_req.sel),
      .addr_i  (acc_idx),
      .wdata_i (acc_req.data),
      .rdata_o (mem_rdata)
   );

   // Write responses and rejected reads return zero; outside RSP the bus
   // is held at zero too, which also gives the reset value.
   assign rsp_valid_o = (state_q == SRAM_RSP_RSP);
   assign data_o      = (rsp_valid_o && rd_ok_q) ? mem_rdata : 32'd0;

`ifdef SRAM_RSP_BOUND_CHK_EN
   assign rsp_err_o = rsp_valid_o && err_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^addr_i[1:0];
`else
   assign rsp_err_o = 1'b0;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[1:0], addr_i[31:AW+2], err_q};
`endif

endmodule

// File: tb/tb_sram_rsp.sv
// ---------------------------------------------------------------------------
// tb_sram_rsp
//   Three responders (WAIT_CYCLES = 0, 3, 2) share a clock. A reference
//   model of the bus contract (memory image plus one pending response per
//   responder, due 1+WAIT_CYCLES cycles after its accept) is checked on
//   every falling edge; directed sequences add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_sram_rsp;

   localparam int NI    = 3;
   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst_n_a     [NI];
   logic [31:0] t_addr      [NI];
   logic [31:0] t_data      [NI];
   logic [3:0]  t_sel       [NI];
   logic        t_we        [NI];
   logic        t_req_valid [NI];
   logic        t_rsp_ready [NI];
   logic        o_req_ready [NI];
   logic [31:0] o_data      [NI];
   logic        o_rsp_valid [NI];
   logic        o_rsp_err   [NI];

   int errs   = 0;
   int checks = 0;
   int tick   = 0;

   // Reference model state.
   logic [31:0] mm    [NI][DEPTH];
   logic        pv    [NI];
   int          pdue  [NI];
   logic [31:0] pdata [NI];
   logic        perr  [NI];
   logic        pwe   [NI];
   logic        poor  [NI];
   int          pidx  [NI];
   logic [31:0] pold  [NI];
   int          acc_cnt [NI];
   int          rsp_cnt [NI];

   always #5 clk = ~clk;

   always @(posedge clk) tick <= tick + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sram_rsp #(
         .DEPTH       (DEPTH),
         .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n_a[g]),
         .addr_i      (t_addr[g]),
         .data_i      (t_data[g]),
         .sel_i       (t_sel[g]),
         .we_i        (t_we[g]),
         .req_valid_i (t_req_valid[g]),
         .req_ready_o (o_req_ready[g]),
         .data_o      (o_data[g]),
         .rsp_valid_o (o_rsp_valid[g]),
         .rsp_ready_i (t_rsp_ready[g]),
         .rsp_err_o   (o_rsp_err[g])
      );
   end

   function automatic int wc(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
   endfunction

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model compare and update, once per cycle per responder.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n_a[i]) begin
            if (pv[i] && pwe[i] && !poor[i] && (pdue[i] > tick)) begin
               mm[i][pidx[i]] = pold[i];
            end
            pv[i] = 1'b0;
            check_output($sformatf("rst_valid%0d", i), 32'(o_rsp_valid[i]), 32'd0);
            check_output($sformatf("rst_data%0d", i), o_data[i], 32'd0);
            check_output($sformatf("rst_err%0d", i), 32'(o_rsp_err[i]), 32'd0);
         end else begin
            logic exp_v;
            logic exp_rdy;
            exp_v   = pv[i] && (pdue[i] <= tick);
            exp_rdy = !pv[i] ? 1'b1 : (exp_v ? t_rsp_ready[i] : 1'b0);
            check_output($sformatf("rsp_valid%0d", i), 32'(o_rsp_valid[i]), 32'(exp_v));
            check_output($sformatf("req_ready%0d", i), 32'(o_req_ready[i]), 32'(exp_rdy));
            if (exp_v) begin
               check_output($sformatf("data%0d", i), o_data[i], pdata[i]);
               check_output($sformatf("err%0d", i), 32'(o_rsp_err[i]), 32'(perr[i]));
               if (o_rsp_valid[i] && t_rsp_ready[i]) begin
                  pv[i] = 1'b0;
                  rsp_cnt[i]++;
               end
            end
            if (t_req_valid[i] && o_req_ready[i]) begin
               int  idx;
               logic oor;
               if (pv[i]) begin
                  check_output($sformatf("overlap%0d", i), 32'd1, 32'd0);
               end
               idx = int'((t_addr[i] >> 2) % DEPTH);
`ifdef SRAM_RSP_BOUND_CHK_EN
               oor = (t_addr[i] >> 2) >= DEPTH;
`else
               oor = 1'b0;
`endif
               pv[i]   = 1'b1;
               pdue[i] = tick + 1 + wc(i);
               pwe[i]  = t_we[i];
               poor[i] = oor;
               pidx[i] = idx;
               perr[i] = oor;
               pold[i] = mm[i][idx];
               if (t_we[i]) begin
                  pdata[i] = 32'd0;
                  if (!oor) begin
                     for (int k = 0; k < 4; k++) begin
                        if (t_sel[i][k]) mm[i][idx][8*k +: 8] = t_data[i][8*k +: 8];
                     end
                  end
               end else begin
                  pdata[i] = oor ? 32'd0 : mm[i][idx];
               end
               acc_cnt[i]++;
            end
         end
      end
   end

   task automatic apply_stimulus(input int i, input logic we, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
      t_we[i]        = we;
      t_addr[i]      = a;
      t_data[i]      = d;
      t_sel[i]       = s;
      t_req_valid[i] = 1'b1;
   endtask

   task automatic wait_accept(input int i, output int t);
      logic acc = 1'b0;
      t = 0;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         if (o_req_ready[i]) begin
            acc = 1'b1;
            t   = tick;
         end
         @(posedge clk);
         #2;
      end
      t_req_valid[i] = 1'b0;
      if (!acc) check_output("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input int i, input logic need_hs, output logic [31:0] d,
                           output logic e, output int t);
      logic got = 1'b0;
      d = '0;
      e = 1'b0;
      t = 0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (o_rsp_valid[i] && (t_rsp_ready[i] || !need_hs)) begin
            got = 1'b1;
            d   = o_data[i];
            e   = o_rsp_err[i];
            t   = tick;
         end
         if (!got || need_hs) begin
            @(posedge clk);
            #2;
         end
      end
      if (!got) check_output("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic txn(input int i, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic re, output int lat);
      int ta, tr;
      apply_stimulus(i, we, a, d, s);
      wait_accept(i, ta);
      wait_rsp(i, 1'b1, rd, re, tr);
      lat = tr - ta;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        re;
      int          lat, ta, tb0, a0, r0;

      for (int i = 0; i < NI; i++) begin
         rst_n_a[i] = 1'b0;  t_addr[i] = '0; t_data[i] = '0; t_sel[i] = '0;
         t_we[i] = 1'b0;     t_req_valid[i] = 1'b0; t_rsp_ready[i] = 1'b1;
         pv[i] = 1'b0;       acc_cnt[i] = 0; rsp_cnt[i] = 0;
      end
      repeat (3) @(posedge clk);
      #2;
      check_output("reset_rsp_valid", 32'(o_rsp_valid[0]), 32'd0);
      check_output("reset_data", o_data[0], 32'd0);
      for (int i = 0; i < NI; i++) rst_n_a[i] = 1'b1;
      @(posedge clk);
      #2;
      check_output("reset_req_ready", 32'(o_req_ready[0]), 32'd1);

      $display("[TB] basic write/read, WAIT_CYCLES=0");
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, re, lat);
      check_output("wr_latency", 32'(lat), 32'd1);
      check_output("wr_data_zero", rd, 32'd0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, re, lat);
      check_output("rd_latency", 32'(lat), 32'd1);
      check_output("rd_deadbeef", rd, 32'hDEADBEEF);

      $display("[TB] byte lanes");
      txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, re, lat);
      txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, re, lat);
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, re, lat);
      check_output("lanes_0101", rd, 32'h11BB33DD);
      txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, re, lat);
      txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, re, lat);
      check_output("sel0_noop", rd, 32'h11BB33DD);

      $display("[TB] backpressure");
      t_rsp_ready[0] = 1'b0;
      apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0);
      wait_accept(0, ta);
      apply_stimulus(0, 1'b1, 32'h10, 32'h0BADCAFE, 4'hF);
      a0 = acc_cnt[0];
      repeat (5) begin
         @(posedge clk);
         #2;
      end
      check_output("bp_no_accept", 32'(acc_cnt[0]), 32'(a0));
      check_output("bp_req_ready", 32'(o_req_ready[0]), 32'd0);
      check_output("bp_rsp_valid", 32'(o_rsp_valid[0]), 32'd1);
      check_output("bp_data", o_data[0], 32'hDEADBEEF);
      t_rsp_ready[0] = 1'b1;
      wait_accept(0, ta);
      repeat (2) @(posedge clk);
      #2;
      check_output("bp_one_accept", 32'(acc_cnt[0]), 32'(a0 + 1));
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, re, lat);
      check_output("bp_write_applied", rd, 32'h0BADCAFE);

      $display("[TB] back-to-back");
      txn(0, 1'b1, 32'h34, 32'h01020304, 4'hF, rd, re, lat);
      a0 = acc_cnt[0];
      apply_stimulus(0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF); wait_accept(0, tb0);
      apply_stimulus(0, 1'b0, 32'h30, 32'h0, 4'h0);        wait_accept(0, ta);
      apply_stimulus(0, 1'b1, 32'h34, 32'hFFFFBEEF, 4'h3); wait_accept(0, ta);
      apply_stimulus(0, 1'b0, 32'h34, 32'h0, 4'h0);        wait_accept(0, ta);
      apply_stimulus(0, 1'b0, 32'h30, 32'h0, 4'h0);        wait_accept(0, ta);
      apply_stimulus(0, 1'b1, 32'h30, 32'h00000077, 4'h1); wait_accept(0, ta);
      apply_stimulus(0, 1'b0, 32'h30, 32'h0, 4'h0);        wait_accept(0, ta);
      apply_stimulus(0, 1'b0, 32'h34, 32'h0, 4'h0);        wait_accept(0, ta);
      check_output("b2b_throughput", 32'(ta - tb0), 32'd7);
      repeat (2) @(posedge clk);
      #2;
      check_output("b2b_accepts", 32'(acc_cnt[0] - a0), 32'd8);
      txn(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, re, lat);
      check_output("b2b_word30", rd, 32'hA5A5A577);
      txn(0, 1'b0, 32'h34, 32'h0, 4'h0, rd, re, lat);
      check_output("b2b_word34", rd, 32'h0102BEEF);

      $display("[TB] address range");
      txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, re, lat);
      txn(0, 1'b0, 32'h4000, 32'h0, 4'h0, rd, re, lat);
`ifdef SRAM_RSP_BOUND_CHK_EN
      check_output("oor_rd_err", 32'(re), 32'd1);
      check_output("oor_rd_data", rd, 32'd0);
`else
      check_output("alias_rd_err", 32'(re), 32'd0);
      check_output("alias_rd_data", rd, 32'hCAFEF00D);
`endif
      txn(0, 1'b1, 32'h4000, 32'h00000099, 4'hF, rd, re, lat);
      txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, re, lat);
`ifdef SRAM_RSP_BOUND_CHK_EN
      check_output("oor_wr_dropped", rd, 32'hCAFEF00D);
`else
      check_output("alias_wr_applied", rd, 32'h00000099);
`endif

      $display("[TB] WAIT_CYCLES=3 streaming");
      for (int k = 0; k < 8; k++) begin
         txn(1, 1'b1, 32'h100 + 32'(4 * k), 32'h10000000 + 32'(k * 32'h01010101), 4'hF, rd, re, lat);
      end
      txn(1, 1'b0, 32'h104, 32'h0, 4'h0, rd, re, lat);
      check_output("w3_latency", 32'(lat), 32'd4);
      check_output("w3_data", rd, 32'h11010101);
      a0 = acc_cnt[1];
      r0 = rsp_cnt[1];
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'h0);
         wait_accept(1, ta);
      end
      repeat (8) @(posedge clk);
      #2;
      check_output("w3_accepts", 32'(acc_cnt[1] - a0), 32'd8);
      check_output("w3_responses", 32'(rsp_cnt[1] - r0), 32'd8);

      $display("[TB] reset mid-transaction, WAIT_CYCLES=2");
      txn(2, 1'b1, 32'h40, 32'h55AA55AA, 4'hF, rd, re, lat);
      check_output("w2_latency", 32'(lat), 32'd3);
      t_rsp_ready[2] = 1'b0;
      apply_stimulus(2, 1'b0, 32'h40, 32'h0, 4'h0);
      wait_accept(2, ta);
      wait_rsp(2, 1'b0, rd, re, lat);
      check_output("held_read", rd, 32'h55AA55AA);
      @(posedge clk);
      #2;
      rst_n_a[2] = 1'b0;
      #1;
      check_output("rst_drop_valid", 32'(o_rsp_valid[2]), 32'd0);
      check_output("rst_drop_data", o_data[2], 32'd0);
      @(posedge clk);
      #2;
      rst_n_a[2] = 1'b1;
      t_rsp_ready[2] = 1'b1;
      @(posedge clk);
      #2;
      apply_stimulus(2, 1'b1, 32'h40, 32'h12345678, 4'hF);
      wait_accept(2, ta);
      rst_n_a[2] = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n_a[2] = 1'b1;
      @(posedge clk);
      #2;
      txn(2, 1'b0, 32'h40, 32'h0, 4'h0, rd, re, lat);
      check_output("aborted_write", rd, 32'h55AA55AA);

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
